// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit.
// Holds op encodings, FSM states and the default datapath width.
package mdu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the register-file stage and the MDU.
// master drives operands and MTHI/MTLO writes; slave returns status and HI/LO.
interface mdu_if #(
    parameter int WIDTH = mdu_pkg::WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] data_t;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data_s, data_t, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data_s, data_t, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_div_step.sv
// One radix-2 restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, and report the quotient bit.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;

    // rem_i < div_i holds, so the shifted value fits after a failed trial
    assign trial = {rem_i, bit_i} - {1'b0, div_i};
    assign q_o   = ~trial[WIDTH];
    assign rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-multiply path (IDLE -> FIX).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = mdu_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input logic   clk,
    input logic   rst_n,
    mdu_if.slave  bus
);

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, s_raw_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               mul_q, neg_lo_q, neg_hi_q, dz_q, done_q;

    logic               mul_in, sgn_in, s_neg, t_neg;
    logic [WIDTH-1:0]   abs_s, abs_t;
    logic               last, fix_hold;

    assign mul_in = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign sgn_in = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign s_neg  = sgn_in & bus.data_s[WIDTH-1];
    assign t_neg  = sgn_in & bus.data_t[WIDTH-1];
    assign abs_s  = s_neg ? -bus.data_s : bus.data_s;
    assign abs_t  = t_neg ? -bus.data_t : bus.data_t;

    assign last     = cnt_q == CNT_W'(WIDTH - 1);
    // fast multiply spends one FIX cycle registering the product
    assign fix_hold = FAST && mul_q && (cnt_q == '0);

    logic [WIDTH-1:0]   rem_nx;
    logic               q_nx;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] step_nx, prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .bit_i (acc_q[WIDTH-1]),
        .div_i (a_q),
        .rem_o (rem_nx),
        .q_o   (q_nx)
    );

    assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, a_q} : '0);

    assign step_nx = mul_q ? {msum, acc_q[WIDTH-1:1]}
                           : {rem_nx, acc_q[WIDTH-2:0], q_nx};

    assign prod = neg_lo_q ? -acc_q : acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (!mul_q) begin
            if (dz_q) begin
                res_hi = s_raw_q;
                res_lo = '1;
            end else begin
                res_hi = neg_hi_q ? -rem : rem;
                res_lo = neg_lo_q ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = (FAST && mul_in) ? FIX : CALC;
            CALC: if (last)      state_d = FIX;
            FIX:  state_d = fix_hold ? FIX : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            s_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mul_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        cnt_q    <= '0;
                        a_q      <= abs_t;
                        s_raw_q  <= bus.data_s;
                        acc_q    <= {{WIDTH{1'b0}}, abs_s};
                        mul_q    <= mul_in;
                        neg_lo_q <= s_neg ^ t_neg;
                        neg_hi_q <= s_neg;
                        dz_q     <= bus.data_t == '0;
                    end
                end
                CALC: begin
                    acc_q <= step_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (fix_hold) begin
                        acc_q <= {{WIDTH{1'b0}}, a_q}
                               * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
                        cnt_q <= CNT_W'(1);
                    end else begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
